scan_chain_driver: RTL and testbench



---
 rtl/scan_chain_driver.sv | 145 ++++++++++++++
 tb/tb_scan_chain_driver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_driver.sv
// scan_chain_driver: serial transmitter for the DPE scan chain.
// Host words arrive over a valid/ready handshake. Each word is shifted LSB-first
// into the chain head (sc_d/sc_en). A capture pulse (sc_ld) starts each frame.
// Optional macro SCAN_READBACK_EN: samples the chain tail while shifting and
// returns the previously captured contents word by word on m_valid/m_data.
// With the macro undefined, m_valid and m_data are tied to 0 and sc_tail is ignored.
module scan_chain_driver #(
  parameter int WORD_W    = 8,
  parameter int NUM_WORDS = 8,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              sc_d,
  output logic              sc_en,
  output logic              sc_ld,
  input  logic              sc_tail,
  output logic              m_valid,
  output logic [WORD_W-1:0] m_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    CAPT,
    SHIFT,
    WAIT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bitcnt;
  logic [CNT_W-1:0]  wordcnt;

  // The last shift cycle of a word also completes one readback word.
  logic last_bit;
  assign last_bit = (state == SHIFT) && (bitcnt == LAST_BIT);

  // Frame sequencer: handshake, capture, shift each word, wait for the next word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: sequential state uses non-blocking assignments, so every branch
      // below reads the pre-edge values of shreg and the counters.
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      wordcnt <= '0;
    end else if (clr) begin
      // Abort: the chain keeps whatever has been shifted into it so far.
      state   <= IDLE;
      bitcnt  <= '0;
      wordcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            shreg   <= s_data;
            wordcnt <= '0;
            state   <= CAPT;
          end
        end
        CAPT: begin
          bitcnt <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          shreg <= shreg >> 1;
          if (bitcnt == LAST_BIT) begin
            bitcnt <= '0;
            if (wordcnt == LAST_WORD) begin
              state <= DONE;
            end else begin
              wordcnt <= wordcnt + CNT_W'(1);
              state   <= WAIT;
            end
          end else begin
            bitcnt <= bitcnt + CNT_W'(1);
          end
        end
        WAIT: begin
          // No capture between words: go straight back to shifting.
          if (s_valid) begin
            shreg <= s_data;
            state <= SHIFT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decodes use only the state register and shreg, never an input.
  assign s_ready = (state == IDLE) || (state == WAIT);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign sc_ld   = (state == CAPT);
  assign sc_en   = (state == SHIFT);
  assign sc_d    = sc_en & shreg[0];

`ifdef SCAN_READBACK_EN
  logic [WORD_W-1:0] rb;

  // Readback: collect the chain tail MSB-first-in so the first bit out lands at bit 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rb      <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (clr) begin
      m_valid <= 1'b0;
    end else begin
      m_valid <= last_bit;
      if (state == SHIFT) begin
        rb <= {sc_tail, rb[WORD_W-1:1]};
      end
      if (last_bit) begin
        m_data <= {sc_tail, rb[WORD_W-1:1]};
      end
    end
  end
`else
  // Readback removed. The names below are recognized as deliberately unused.
  logic unused_tail;
  logic unused_last_bit;
  assign unused_tail     = sc_tail;
  assign unused_last_bit = last_bit;
  assign m_valid         = 1'b0;
  assign m_data          = '0;
`endif

endmodule

// File: tb/tb_scan_chain_driver.sv
// tb_scan_chain_driver: table-driven and randomized frames against a scan-chain
// model. The bench checks the final chain contents, the capture/shift/done timing,
// the WAIT hold behaviour, readback, the abort path and the asynchronous reset.
module tb_scan_chain_driver;
  localparam int W = 8;
  localparam int N = 2;
  localparam int L = W * N;

  logic         clk = 1'b0;
  logic         rstn;
  logic         clr;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         sc_d;
  logic         sc_en;
  logic         sc_ld;
  logic         sc_tail;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         busy;
  logic         done;

  logic [L-1:0] chain = '0;
  logic [L-1:0] pd_drive = '0;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [L-1:0] frame;      // word i occupies frame[i*W +: W]
    logic [L-1:0] pd;         // parallel data the chain captures on sc_ld
    int           stall;      // WAIT cycles before each later word (0 = s_valid held)
    logic [L-1:0] exp_chain;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  scan_chain_driver #(.WORD_W(W), .NUM_WORDS(N), .CNT_W(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (clr),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .sc_d    (sc_d),
    .sc_en   (sc_en),
    .sc_ld   (sc_ld),
    .sc_tail (sc_tail),
    .m_valid (m_valid),
    .m_data  (m_data),
    .busy    (busy),
    .done    (done)
  );

  // Model of the scan chain itself: parallel capture, or a shift toward bit 0.
  always @(posedge clk) begin
    if (sc_ld)      chain <= pd_drive;
    else if (sc_en) chain <= {sc_d, chain[L-1:1]};
  end
  assign sc_tail = chain[0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: after a frame, the chain holds the words in handshake order,
  // with word 0 at the lowest bits.
  function automatic logic [L-1:0] model_chain(input logic [L-1:0] frame);
    logic [L-1:0] r;
    logic [W-1:0] wd;
    r = '0;
    for (int i = 0; i < N; i++) begin
      wd = frame[i*W +: W];
      r  = r | (L'(wd) << (i * W));
    end
    return r;
  endfunction

  // Cycle (0 = handshake) in which done is high.
  function automatic int model_done_cycle(input int stall);
    return 2 + N * W + (N - 1) * ((stall == 0) ? 1 : stall);
  endfunction

  task automatic run_frame(input vec_t v);
    int cyc, idx, en_cnt, ld_cnt, ld_cyc, first_en, last_en, done_cyc, both, wait_cnt;
    bit hs, hold_ok;
    logic [W-1:0] rb_q[$];
    logic [L-1:0] snap;
    cyc = 0; idx = 0; en_cnt = 0; ld_cnt = 0; ld_cyc = -1; first_en = -1;
    last_en = -1; done_cyc = -1; both = 0; wait_cnt = 0; hold_ok = 1'b1;
    snap = '0;
    pd_drive = v.pd;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = v.frame[0 +: W];
    while (done_cyc < 0 && cyc < 400) begin
      if (sc_ld) begin ld_cnt++; ld_cyc = cyc; end
      if (sc_en) begin en_cnt++; if (first_en < 0) first_en = cyc; last_en = cyc; end
      if (sc_en && sc_ld) both++;
      if (m_valid) rb_q.push_back(m_data);
      if (done) done_cyc = cyc;
      // WAIT is the only state that is both busy and ready.
      if (s_ready && busy && !s_valid) begin
        if (sc_en) hold_ok = 1'b0;
        if (wait_cnt == 0) snap = chain;
        else if (chain !== snap) hold_ok = 1'b0;
        wait_cnt++;
        if (wait_cnt >= v.stall) begin
          s_valid  = 1'b1;
          s_data   = v.frame[idx*W +: W];
          wait_cnt = 0;
        end
      end
      hs = s_valid && s_ready;
      @(negedge clk);
      cyc++;
      if (hs) begin
        idx++;
        if (idx < N && v.stall == 0) s_data = v.frame[idx*W +: W];
        else s_valid = 1'b0;
      end
    end
    if (done_cyc < 0) begin
      check("frame_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    check("ld_count", ld_cnt, 1);
    check("ld_cycle", ld_cyc, 1);
    check("first_en_cycle", first_en, 2);
    check("en_count", en_cnt, L);
    check("ld_en_overlap", both, 0);
    check("done_after_last_shift", done_cyc, last_en + 1);
    check("done_cycle", done_cyc, model_done_cycle(v.stall));
    check("chain", chain, v.exp_chain);
    if (v.stall > 0) check("wait_hold", hold_ok, 1);
`ifdef SCAN_READBACK_EN
    check("rb_count", rb_q.size(), N);
    for (int i = 0; i < N && i < rb_q.size(); i++)
      check("rb_word", rb_q[i], v.pd[i*W +: W]);
`else
    check("m_valid_quiet", rb_q.size(), 0);
`endif
    check("idle_after_busy", busy, 0);
    check("idle_after_ready", s_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vec_t v;
    rstn = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_sc_en", sc_en, 0);
    check("rst_sc_ld", sc_ld, 0);
    check("rst_sc_d", sc_d, 0);
    check("rst_done", done, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);

    // Directed vectors.
    vecs.push_back('{16'h3CA5, 16'h0000, 0,  16'h3CA5});
    vecs.push_back('{16'h0000, 16'hBEEF, 0,  16'h0000});
    vecs.push_back('{16'h1234, 16'hCAFE, 10, 16'h1234});
    vecs.push_back('{16'hFFFF, 16'h5A5A, 3,  16'hFFFF});
    vecs.push_back('{16'h00FF, 16'hFF00, 1,  16'h00FF});
    // Randomized vectors, expected chain from the reference model.
    for (int i = 0; i < 6; i++) begin
      v.frame     = L'($urandom);
      v.pd        = L'($urandom);
      v.stall     = int'($urandom_range(0, 5));
      v.exp_chain = model_chain(v.frame);
      vecs.push_back(v);
    end
    foreach (vecs[i]) run_frame(vecs[i]);

    // Abort on the 4th SHIFT cycle of word 0.
    pd_drive = 16'h1111;
    @(negedge clk); s_valid = 1'b1; s_data = 8'h77;
    @(negedge clk); s_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      @(negedge clk);
      if (sc_en) n++;
    end
    check("abort_reached_shift", n, 4);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("abort_s_ready", s_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_m_valid", m_valid, 0);
    @(negedge clk);
    check("abort_done_later", done, 0);
    check("abort_m_valid_later", m_valid, 0);
    v = '{16'hC3A5, 16'h7E81, 2, 16'hC3A5};
    run_frame(v);

    // Asynchronous reset mid-frame.
    @(negedge clk); s_valid = 1'b1; s_data = 8'hFF;
    @(negedge clk); s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_sc_en", sc_en, 1);
    #2 rstn = 1'b0;
    #1;
    check("areset_sc_en", sc_en, 0);
    check("areset_sc_d", sc_d, 0);
    check("areset_sc_ld", sc_ld, 0);
    check("areset_busy", busy, 0);
    check("areset_s_ready", s_ready, 1);
    check("areset_done", done, 0);
    check("areset_m_valid", m_valid, 0);
    check("areset_m_data", m_data, 0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    check("post_reset_busy", busy, 0);
    v = '{16'h5AA5, 16'hBEEF, 0, 16'h5AA5};
    run_frame(v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
